mul_div_unit: RTL

//  Iterative MIPS MULT/MULTU/DIV/DIVU engine with HI/LO registers.

---
 rtl/mul_div_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU engine with HI/LO registers.
// One shift-add / restoring shift-subtract step per cycle, then a sign-fix cycle.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] ONE_MAG = (WIDTH + 1)'(1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

  state_e             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               neg_main_q, neg_main_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   rs_raw_q, rs_raw_d;
  logic [WIDTH:0]     opnd_q, opnd_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               is_signed;
  logic [WIDTH:0]     rs_ext, rt_ext, rs_mag, rt_mag;
  logic [WIDTH+1:0]   mul_sum;
  logic [2*WIDTH:0]   mul_next;
  logic [WIDTH:0]     div_top;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [2*WIDTH:0]   div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  // Magnitudes are WIDTH+1 bits so the most negative operand negates exactly.
  always_comb begin
    is_signed = ~op_i[0];
    rs_ext    = {is_signed & rs_data_i[WIDTH-1], rs_data_i};
    rt_ext    = {is_signed & rt_data_i[WIDTH-1], rt_data_i};
    rs_mag    = rs_ext[WIDTH] ? (~rs_ext + ONE_MAG) : rs_ext;
    rt_mag    = rt_ext[WIDTH] ? (~rt_ext + ONE_MAG) : rt_ext;
  end

  // acc holds {partial(W+1), multiplier/dividend(W)}; both ops shift one bit per step.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_top  = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = {1'b0, div_top} - {1'b0, opnd_q};
    div_ok   = ~div_diff[WIDTH+1];
    div_next = {(div_ok ? div_diff[WIDTH:0] : div_top), acc_q[WIDTH-2:0], div_ok};
    prod     = acc_q[2*WIDTH-1:0];
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    is_div_d   = is_div_q;
    neg_main_d = neg_main_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    rs_raw_d   = rs_raw_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (hi_we_i) hi_d = rs_data_i;
        if (lo_we_i) lo_d = rs_data_i;
        if (start_i) begin
          state_d    = S_CALC;
          busy_d     = 1'b1;
          is_div_d   = op_i[1];
          neg_main_d = is_signed & (rs_data_i[WIDTH-1] ^ rt_data_i[WIDTH-1]);
          neg_rem_d  = is_signed & rs_data_i[WIDTH-1];
          div_zero_d = op_i[1] & (rt_data_i == '0);
          rs_raw_d   = rs_data_i;
          cnt_d      = '0;
          if (op_i[1]) begin
            opnd_d = rt_mag;
            acc_d  = {{(WIDTH + 1){1'b0}}, rs_mag[WIDTH-1:0]};
          end else begin
            opnd_d = rs_mag;
            acc_d  = {{(WIDTH + 1){1'b0}}, rt_mag[WIDTH-1:0]};
          end
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          // A zero divisor leaves the raw dividend in HI, bypassing sign fix-up.
          lo_d = div_zero_q ? '1 : (neg_main_q ? -quo : quo);
          hi_d = div_zero_q ? rs_raw_q : (neg_rem_q ? -rem : rem);
        end else begin
          {hi_d, lo_d} = neg_main_q ? -prod : prod;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      is_div_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      rs_raw_q   <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      neg_main_q <= neg_main_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      rs_raw_q   <= rs_raw_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
